// File: rtl/load_store_unit_if.sv
// Core/memory-side bundle of the load/store unit.
// slave = LSU view, master = core + data memory view.
interface load_store_unit_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    input  mem_read_data, mem_ack,
    output req_ready, resp_valid,
    output resp_rdata, resp_fault,
    output mem_read, mem_write,
    output mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    output mem_read_data, mem_ack,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_fault,
    input  mem_read, mem_write,
    input  mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle LSU: word-split D accesses, RMW sub-word stores.
// LSU_SUBWORD_STORE_EN enables B/H stores; otherwise they fault.
module load_store_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] WR0  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [31:0]       word0_q, word0_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic [2:0]        f3_in;
  logic [2:0]        a_in;
  logic              misal;
  logic              illegal;
  logic              bad;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] upper;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_w;
  logic [XLEN-1:0]   ld_ext;
  logic [31:0]       wr_word;

  assign accept = bus.req_valid & (state_q == IDLE);
  assign f3_in  = bus.req_funct3;
  assign a_in   = bus.req_addr[2:0];

  assign misal = ((f3_in[1:0] == 2'b01) & a_in[0])
               | ((f3_in[1:0] == 2'b10) & (|a_in[1:0]))
               | ((f3_in == 3'b011) & (|a_in));

`ifdef LSU_SUBWORD_STORE_EN
  assign illegal = (f3_in == 3'b111)
                 | (bus.req_we & f3_in[2]);
`else
  assign illegal = (f3_in == 3'b111)
                 | (bus.req_we & f3_in[2])
                 | (bus.req_we & ~f3_in[1]);
`endif

  assign bad   = misal | illegal;
  assign base  = {addr_q[ADDR_W-1:2], 2'b00};
  assign upper = base + ADDR_W'(4);

  assign ld_w = bus.mem_read_data;
  assign ld_b = ld_w[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = ld_w[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = '0;
    case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_b};
      3'b001:  ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_h};
      3'b010:  ld_ext = {{(XLEN-32){ld_w[31]}}, ld_w};
      3'b110:  ld_ext = {{(XLEN-32){1'b0}}, ld_w};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    wr_word = wdata_q[31:0];
`ifdef LSU_SUBWORD_STORE_EN
    // old word from RD0 with the target lane replaced
    case (f3_q[1:0])
      2'b00: begin
        wr_word = word0_q;
        wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        wr_word = word0_q;
        wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: wr_word = wdata_q[31:0];
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    word0_d = word0_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            bad: begin
              state_d = RESP;
              rdata_d = '0;
              fault_d = 1'b1;
            end
            !bad & (!bus.req_we | !f3_in[1]):
              state_d = RD0;
            !bad & bus.req_we & f3_in[1]:
              state_d = WR0;
          endcase
        end
      end
      RD0: begin
        if (bus.mem_ack) begin
          word0_d = bus.mem_read_data;
`ifdef LSU_SUBWORD_STORE_EN
          if (we_q) begin
            state_d = WR0;
          end else
`endif
          if (f3_q[1:0] == 2'b11) begin
            state_d = RD1;
          end else begin
            state_d = RESP;
            rdata_d = ld_ext;
            fault_d = 1'b0;
          end
        end
      end
      RD1: begin
        if (bus.mem_ack) begin
          state_d = RESP;
          rdata_d = {bus.mem_read_data, word0_q};
          fault_d = 1'b0;
        end
      end
      WR0: begin
        if (bus.mem_ack) begin
          if (f3_q[1:0] == 2'b11) begin
            state_d = WR1;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            fault_d = 1'b0;
          end
        end
      end
      WR1: begin
        if (bus.mem_ack) begin
          state_d = RESP;
          rdata_d = '0;
          fault_d = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    case (state_q)
      RD0: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = base;
      end
      RD1: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = upper;
      end
      WR0: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = base;
        bus.mem_write_data = wr_word;
      end
      WR1: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = upper;
        bus.mem_write_data = wdata_q[63:32];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic
// against a byte-addressed reference memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(64), .ADDR_W(64)) bus ();

  load_store_unit #(.XLEN(64), .ADDR_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        w;
    logic [63:0] a;
    logic [31:0] d;
  } op_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] dmem [64] = '{default: '0};
  logic [31:0] rmem [64] = '{default: '0};
  op_t obs_ops [$];
  op_t exp_ops [$];
  int  strobe_cyc = 0;

  assign bus.mem_read_data = dmem[bus.mem_address[7:2]];

  always @(posedge clk) begin
    if (bus.mem_read | bus.mem_write) strobe_cyc <= strobe_cyc + 1;
    if (bus.mem_ack & (bus.mem_read | bus.mem_write))
      obs_ops.push_back({bus.mem_write, bus.mem_address,
                         bus.mem_write_data});
    if (bus.mem_ack & bus.mem_write & !rst)
      dmem[bus.mem_address[7:2]] <= bus.mem_write_data;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] getb(input logic [63:0] a);
    return rmem[a[7:2]][{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic void setb(input logic [63:0] a,
                               input logic [7:0] v);
    rmem[a[7:2]][{a[1:0], 3'b000} +: 8] = v;
  endfunction

  function automatic logic [31:0] wordat(input logic [63:0] a);
    return rmem[a[7:2]];
  endfunction

  // Reference: byte-level memory semantics, ops list, result.
  function automatic void model(input bit we, input logic [2:0] f3,
      input logic [63:0] a, input logic [63:0] wd,
      output bit flt, output logic [63:0] rd);
    int sz;
    bit ill;
    logic [63:0] wb;
    sz = 1 << f3[1:0];
    ill = (f3 == 3'b111) || (we && f3[2]);
`ifndef LSU_SUBWORD_STORE_EN
    if (we && sz < 4) ill = 1;
`endif
    exp_ops.delete();
    rd = 0;
    flt = ill || ((a & 64'(sz - 1)) != 0);
    if (flt) return;
    wb = {a[63:2], 2'b00};
    if (!we) begin
      for (int i = 0; i < sz; i++)
        rd |= 64'(getb(a + 64'(i))) << (8 * i);
      if (!f3[2] && sz < 8 && rd[8*sz-1])
        rd |= ~64'd0 << (8 * sz);
      if (sz == 8) begin
        exp_ops.push_back({1'b0, a, 32'd0});
        exp_ops.push_back({1'b0, a + 64'd4, 32'd0});
      end else begin
        exp_ops.push_back({1'b0, wb, 32'd0});
      end
    end else begin
      if (sz < 4) exp_ops.push_back({1'b0, wb, 32'd0});
      for (int i = 0; i < sz; i++)
        setb(a + 64'(i), wd[8*i +: 8]);
      if (sz == 8) begin
        exp_ops.push_back({1'b1, a, wordat(a)});
        exp_ops.push_back({1'b1, a + 64'd4, wordat(a + 64'd4)});
      end else begin
        exp_ops.push_back({1'b1, wb, wordat(wb)});
      end
    end
  endfunction

  // mode 0: ack=1, mode 1: random ack, mode 2: stall 3 in RD1
  task automatic txn(input bit we, input logic [2:0] f3,
      input logic [63:0] a, input logic [63:0] wd, input int mode,
      output int lat, output logic [63:0] rd, output bit flt);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.mem_ack    = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = {$urandom, $urandom};
        bus.req_wdata  = {$urandom, $urandom};
      end
      if (mode == 1) bus.mem_ack = ($urandom_range(0, 2) != 0);
      else if (mode == 2) bus.mem_ack = !(lat >= 2 && lat <= 4);
      else bus.mem_ack = 1'b1;
      if (mode == 2 && lat >= 2 && lat <= 4)
        chk("stall_addr", bus.mem_address, 64'h44);
    end while (!bus.resp_valid && lat < 64);
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b1;
    if (!bus.resp_valid) chk("timeout", 64'd0, 64'd1);
    rd  = bus.resp_rdata;
    flt = bus.resp_fault;
  endtask

  int          r_lat;
  logic [63:0] r_rd;
  bit          r_flt;
  op_t         r_ops [$];
  int          r_strobes;

  task automatic run(input bit we, input logic [2:0] f3,
      input logic [63:0] a, input logic [63:0] wd, input int mode);
    bit e_flt;
    logic [63:0] e_rd;
    int o0, s0;
    model(we, f3, a, wd, e_flt, e_rd);
    o0 = obs_ops.size();
    s0 = strobe_cyc;
    txn(we, f3, a, wd, mode, r_lat, r_rd, r_flt);
    r_strobes = strobe_cyc - s0;
    r_ops.delete();
    for (int i = o0; i < obs_ops.size(); i++) r_ops.push_back(obs_ops[i]);
    chk("fault", 64'(r_flt), 64'(e_flt));
    chk("rdata", r_rd, e_rd);
    chk("n_ops", 64'(r_ops.size()), 64'(exp_ops.size()));
    if (mode == 0) begin
      chk("latency", 64'(r_lat), 64'(exp_ops.size() + 1));
      chk("strobes", 64'(r_strobes), 64'(exp_ops.size()));
    end
    for (int i = 0; i < r_ops.size() && i < exp_ops.size(); i++) begin
      chk("op_kind", 64'(r_ops[i].w), 64'(exp_ops[i].w));
      chk("op_addr", r_ops[i].a, exp_ops[i].a);
      if (exp_ops[i].w) chk("op_wdata", 64'(r_ops[i].d), 64'(exp_ops[i].d));
    end
  endtask

  initial begin
    bit          seen;
    bit          rwe;
    logic [2:0]  rf3;
    logic [63:0] ra;
    int          sz;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_fault", 64'(bus.resp_fault), 64'd0);
    chk("rst_strobe", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("rst_maddr", bus.mem_address, 64'd0);
    chk("rst_mwdata", 64'(bus.mem_write_data), 64'd0);
    rst = 1'b0;

    run(1, 3'b010, 64'h10, 64'h8000_00F0, 0);
    run(0, 3'b010, 64'h10, 64'h0, 0);
    chk("lw_val", r_rd, 64'hFFFF_FFFF_8000_00F0);
    chk("lw_lat", 64'(r_lat), 64'd2);
    run(0, 3'b110, 64'h10, 64'h0, 0);
    chk("lwu_val", r_rd, 64'h0000_0000_8000_00F0);

    run(1, 3'b010, 64'h10, 64'h8A00_0000, 0);
    run(0, 3'b000, 64'h13, 64'h0, 0);
    chk("lb_val", r_rd, 64'hFFFF_FFFF_FFFF_FF8A);
    run(0, 3'b100, 64'h13, 64'h0, 0);
    chk("lbu_val", r_rd, 64'h8A);

    run(1, 3'b010, 64'h20, 64'h1122_3344, 0);
    run(1, 3'b000, 64'h21, 64'h5A, 0);
`ifdef LSU_SUBWORD_STORE_EN
    chk("sb_lat", 64'(r_lat), 64'd3);
    chk("sb_nops", 64'(r_ops.size()), 64'd2);
    if (r_ops.size() == 2) begin
      chk("sb_rd_addr", r_ops[0].a, 64'h20);
      chk("sb_wr_data", 64'(r_ops[1].d), 64'h1122_5A44);
    end
`else
    chk("sb_fault", 64'(r_flt), 64'd1);
    chk("sb_strobes", 64'(r_strobes), 64'd0);
`endif

    run(1, 3'b011, 64'h40, 64'h0123_4567_89AB_CDEF, 0);
    chk("sd_nops", 64'(r_ops.size()), 64'd2);
    if (r_ops.size() == 2) begin
      chk("sd_w0", {r_ops[0].a[31:0], r_ops[0].d},
          64'h0000_0040_89AB_CDEF);
      chk("sd_w1", {r_ops[1].a[31:0], r_ops[1].d},
          64'h0000_0044_0123_4567);
    end
    run(0, 3'b011, 64'h40, 64'h0, 0);
    chk("ld_val", r_rd, 64'h0123_4567_89AB_CDEF);

    run(0, 3'b001, 64'h31, 64'h0, 0);
    chk("lh_mis", {32'(r_lat), 31'd0, r_flt}, {32'd1, 32'd1});
    run(1, 3'b010, 64'h42, 64'hDEAD, 0);
    chk("sw_mis", {32'(r_strobes), 31'd0, r_flt}, {32'd0, 32'd1});
    run(0, 3'b111, 64'h40, 64'h0, 0);
    chk("f3_111", 64'(r_flt), 64'd1);

    run(0, 3'b011, 64'h40, 64'h0, 2);
    chk("stall_lat", 64'(r_lat), 64'd6);
    chk("stall_val", r_rd, 64'h0123_4567_89AB_CDEF);

    // reset while stalled in RD1
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h40;
    bus.mem_ack    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rst_in_rd1", 64'(bus.mem_address), 64'h44);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_strobe", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    seen = bus.resp_valid;
    repeat (4) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    chk("rst_mid_noresp", 64'(seen), 64'd0);

    for (int k = 0; k < 400; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      sz  = 1 << rf3[1:0];
      if ($urandom_range(0, 3) != 0) ra &= ~64'(sz - 1);
      run(rwe, rf3, ra, {$urandom, $urandom}, (k < 200) ? 0 : 1);
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++)
      chk("mem_image", 64'(dmem[i]), 64'(rmem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's execute stage and the word-organised data memory. Accepts one load or store per request, splits doubleword accesses into two word transactions, and performs byte/halfword stores as read-modify-write. Extracts and sign/zero-extends load data, and reports misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- `XLEN`, 64: core data width.
- `ADDR_W`, 64: byte address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on the edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V width code. Values: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in XLEN: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load data. It is 0 for stores and faults.
- `resp_fault` out 1: misaligned or illegal request. Qualified by `resp_valid`.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out ADDR_W: byte address, always with `[1:0]` = 0.
- `mem_write_data` out 32: word to write.
- `mem_read_data` in 32: word read.
- `mem_ack` in 1: memory completes the current phase at this edge. A single-cycle memory ties this to 1.

## Operation
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- On accept, latch `we`, `funct3`, `addr` and `wdata`. Later changes on `req_*` are ignored.
- Fault check at accept:
  - Misaligned: H/HU with `addr[0]`≠0; W/WU with `addr[1:0]`≠0; D with `addr[2:0]`≠0.
  - Illegal: funct3 111, or a store with `funct3[2]`=1.
  - On a fault, go directly to RESP with `resp_fault`=1. No memory strobe is asserted.
- Loads:
  - B/H/W/BU/HU/WU: RD0 at `{addr[63:2],2'b00}`, then RESP.
    - Select the byte by `addr[1:0]` and the half by `addr[1]`.
    - Sign-extend for B/H/W; zero-extend for BU/HU/WU.
  - D: RD0 at `addr`, RD1 at `addr+4`, then RESP. Result is `{word1,word0}` (little-endian).
- Stores:
  - W: WR0 writes `wdata[31:0]`, then RESP.
  - D: WR0 writes `wdata[31:0]` at `addr`, WR1 writes `wdata[63:32]` at `addr+4`, then RESP.
  - B/H: RD0 captures the old word, then WR0 writes the old word with the target byte/half replaced by `wdata[7:0]`/`wdata[15:0]`, then RESP.
- Each memory state:
  - Asserts exactly one of `mem_read`/`mem_write`.
  - Holds `mem_address` and `mem_write_data` stable.
  - Advances only on an edge with `mem_ack`=1, capturing `mem_read_data` on that edge.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
- Outside memory states, `mem_read`=`mem_write`=0, and `mem_address`/`mem_write_data` are 0.

## Timing
- All outputs are registered or decoded from state. No combinational path from `req_*` to outputs except none: `req_ready` is decoded from state only.
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_fault`=0; all `mem_*` outputs 0.
- Latency from the accept edge to the `resp_valid` cycle, with `mem_ack` tied 1:
  - Fault: 1 cycle.
  - W load/store, or sub-word load: 2 cycles.
  - D access or sub-word store: 3 cycles.
- Each cycle with `mem_ack`=0 adds one cycle.
- `resp_rdata` and `resp_fault` hold their values until the next RESP. Consumers use them only when `resp_valid`=1.
- `req_valid` during RD/WR/RESP is not accepted. A new request is accepted in the cycle after RESP, at the earliest.
- Address `addr+4` wraps modulo 2^ADDR_W.
- `rst` in any state returns to IDLE on that edge. The in-flight response is dropped and no `resp_valid` is issued. A write whose `mem_ack` coincides with `rst` may already be committed in memory.

## Configuration
- `LSU_SUBWORD_STORE_EN`:
  - Defined: B/H stores use RMW as above.
  - Undefined: B/H stores are illegal and fault in 1 cycle with no memory access. The RD-before-WR path and merge logic are not synthesised. Loads are unaffected.

## Test plan
- LW at 0x10, memory word 0x8000_00F0, ack tied 1:
  - `resp_valid` 2 cycles after accept.
  - `resp_rdata`=0xFFFF_FFFF_8000_00F0.
  - LWU of the same word returns 0x0000_0000_8000_00F0.
- LB at 0x13, word 0x8A00_0000:
  - LB returns 0xFFFF_FFFF_FFFF_FF8A.
  - LBU returns 0x8A.
- SB 0x5A at 0x21, old word 0x1122_3344:
  - One read of 0x20, then one write of 0x1122_5A44.
  - `resp_valid` 3 cycles after accept.
  - With `LSU_SUBWORD_STORE_EN` undefined: `resp_fault`=1 and no strobes.
- SD 0x0123_4567_89AB_CDEF at 0x40:
  - Writes 0x89AB_CDEF to 0x40, then 0x0123_4567 to 0x44.
  - LD from 0x40 returns the original value.
- LH at 0x31 and SW at 0x42:
  - `resp_fault`=1 one cycle after accept.
  - `mem_read`/`mem_write` never asserted.
  - funct3=111 also faults.
- LD with `mem_ack` held low for 3 cycles in RD1, then `rst` pulsed mid-RD1 on a repeat run:
  - First run: the address holds 0x44 during the stall, and the response arrives 6 cycles after accept.
  - Second run: IDLE next cycle, `req_ready`=1, no `resp_valid`.
